// File: rtl/fd_inst_queue.sv
// Instruction queue between fetch and decode: an in-order circular buffer of assembled
// instructions with a valid/ready output, a redirect flush and a sticky overflow flag.
module fd_inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     f_push,
    input  logic [47:0]              f_inst,
    input  logic [31:0]              f_pc,
    input  logic [31:0]              f_next_pc,
    input  logic                     f_mode,
    output logic                     q_full,
    input  logic                     flush,
    input  logic                     d_ready,
    output logic                     d_valid,
    output logic [47:0]              d_inst,
    output logic [31:0]              d_pc,
    output logic [31:0]              d_next_pc,
    output logic                     d_mode,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 48 + 32 + 32 + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          full;
    logic          push_ok;
    logic          pop_ok;
    logic [EW-1:0] head;

    assign full    = (count == CW'(DEPTH));
    assign d_valid = (count != '0);
    assign push_ok = f_push & ~full & ~flush;
    assign pop_ok  = d_ready & d_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Redirect: drop everything buffered; storage is left as-is since count gates it.
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {f_inst, f_pc, f_next_pc, f_mode};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (f_push && full) begin
                overflow <= 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Outputs come only from registered state, zeroed while the queue is empty.
    assign head       = d_valid ? mem[rd_ptr] : '0;
    assign d_inst     = head[EW-1 -: 48];
    assign d_pc       = head[64:33];
    assign d_next_pc  = head[32:1];
    assign d_mode     = head[0];
    assign q_full     = full;
    assign q_count    = count;
    assign q_overflow = overflow;
endmodule
